cpu_load_store: RTL

Load/store unit between the execute stage and the data cache in the RV32 core. It takes one memory operation at a time from execute and aligns or sign-extends load data. Sub-word stores use read-modify-write, because the data-cache port carries full 32-bit words with no byte strobes. Misaligned accesses and bus timeouts are reported as faults instead of being issued.

---
 rtl/cpu_load_store.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_load_store.sv
// cpu_load_store: RV32 load/store unit between execute and the data cache.
// Handles one operation at a time. Loads are shifted and sign/zero-extended;
// byte and half stores are done as read-modify-write because the cache port
// only moves whole words. Misaligned accesses and cache timeouts complete
// with o_fault instead of touching the cache.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_request; captures the operation
// READ   | cache read outstanding (load, or first half of an RMW)
// MODIFY | one cycle with the cache request low; merges store data
// WRITE  | cache write outstanding (word store, or second half of an RMW)
// DONE   | o_ready held until execute drops i_request
module cpu_load_store #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [1:0]  i_width,
    input  logic        i_unsigned,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_dc_rw,
    output logic        o_dc_request,
    input  logic        i_dc_ready,
    output logic [31:0] o_dc_address,
    input  logic [31:0] i_dc_rdata,
    output logic [31:0] o_dc_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MODIFY,
        WRITE,
        DONE
    } state_t;

    state_t      state_q;
    logic        rw_q;
    logic [1:0]  width_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [31:0] rmw_q;
    logic [31:0] timer_q;

    logic        ready_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        dc_rw_q;
    logic        dc_req_q;
    logic [31:0] dc_addr_q;
    logic [31:0] dc_wdata_q;

    logic        misaligned_d;
    logic        issue_read_d;
    logic [31:0] shifted_d;
    logic [31:0] load_d;
    logic [31:0] merged_d;
    logic [31:0] timer_d;
    logic        timeout_d;

    // Classify the incoming request: alignment fault, and whether it starts with a read
    always_comb begin
        misaligned_d = 1'b0;
        if (i_width == 2'd1) begin
            misaligned_d = i_address[0];
        end else if (i_width[1]) begin
            misaligned_d = (i_address[1:0] != 2'b00);
        end
        issue_read_d = !i_rw || !i_width[1];
    end

    // Align the returned word to the byte offset and extend to 32 bits
    always_comb begin
        shifted_d = i_dc_rdata >> {off_q, 3'b000};
        case (width_q)
            2'd0:    load_d = {{24{~unsigned_q & shifted_d[7]}}, shifted_d[7:0]};
            2'd1:    load_d = {{16{~unsigned_q & shifted_d[15]}}, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    // Overlay the sub-word store data onto the word read back from the cache
    always_comb begin
        merged_d = rmw_q;
        if (width_q == 2'd0) begin
            case (off_q)
                2'd0:    merged_d[7:0]   = wdata_q[7:0];
                2'd1:    merged_d[15:8]  = wdata_q[7:0];
                2'd2:    merged_d[23:16] = wdata_q[7:0];
                default: merged_d[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged_d[31:16] = wdata_q;
        end else begin
            merged_d[15:0] = wdata_q;
        end
    end

    // Wait-cycle count after this cycle and whether it hits the abort limit
    always_comb begin
        timer_d   = timer_q + 32'd1;
        timeout_d = (TIMEOUT != 0) && (timer_d >= TIMEOUT);
    end

    // Operation sequencer with registered outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            width_q    <= 2'd0;
            unsigned_q <= 1'b0;
            off_q      <= 2'd0;
            wdata_q    <= 16'd0;
            rmw_q      <= 32'd0;
            timer_q    <= 32'd0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            fault_q    <= 1'b0;
            dc_rw_q    <= 1'b0;
            dc_req_q   <= 1'b0;
            dc_addr_q  <= 32'd0;
            dc_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_q <= 32'd0;
                    if (i_request) begin
                        rw_q       <= i_rw;
                        width_q    <= i_width;
                        unsigned_q <= i_unsigned;
                        off_q      <= i_address[1:0];
                        wdata_q    <= i_wdata[15:0];
                        dc_addr_q  <= {i_address[31:2], 2'b00};
                        if (misaligned_d) begin
                            fault_q <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else if (issue_read_d) begin
                            dc_req_q <= 1'b1;
                            dc_rw_q  <= 1'b0;
                            state_q  <= READ;
                        end else begin
                            dc_req_q   <= 1'b1;
                            dc_rw_q    <= 1'b1;
                            dc_wdata_q <= i_wdata;
                            state_q    <= WRITE;
                        end
                    end
                end

                READ: begin
                    if (i_dc_ready) begin
                        dc_req_q <= 1'b0;
                        timer_q  <= 32'd0;
                        if (!rw_q) begin
                            rdata_q <= load_d;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rmw_q   <= i_dc_rdata;
                            state_q <= MODIFY;
                        end
                    end else if (timeout_d) begin
                        dc_req_q <= 1'b0;
                        timer_q  <= 32'd0;
                        fault_q  <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end

                MODIFY: begin
                    // Request stays low this cycle so the read and write are separate transfers
                    dc_wdata_q <= merged_d;
                    dc_req_q   <= 1'b1;
                    dc_rw_q    <= 1'b1;
                    timer_q    <= 32'd0;
                    state_q    <= WRITE;
                end

                WRITE: begin
                    if (i_dc_ready) begin
                        dc_req_q <= 1'b0;
                        dc_rw_q  <= 1'b0;
                        timer_q  <= 32'd0;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else if (timeout_d) begin
                        dc_req_q <= 1'b0;
                        dc_rw_q  <= 1'b0;
                        timer_q  <= 32'd0;
                        fault_q  <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end

                DONE: begin
                    timer_q <= 32'd0;
                    if (!i_request) begin
                        ready_q <= 1'b0;
                        fault_q <= 1'b0;
                        rdata_q <= 32'd0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_rdata      = rdata_q;
    assign o_fault      = fault_q;
    assign o_dc_rw      = dc_rw_q;
    assign o_dc_request = dc_req_q;
    assign o_dc_address = dc_addr_q;
    assign o_dc_wdata   = dc_wdata_q;

endmodule
